// File: rtl/legv8_hazard_unit_if.sv
// legv8_hazard_unit_if: ID-stage inputs, branch resolution and pipeline
// control outputs of the LEGv8 hazard unit.
// The pipeline side uses the master modport and the hazard unit uses the slave modport.
interface legv8_hazard_unit_if #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
);
  logic                   id_valid;
  logic [REG_ADDR_W-1:0]  id_rs1;
  logic [REG_ADDR_W-1:0]  id_rs2;
  logic                   id_use_rs1;
  logic                   id_use_rs2;
  logic [REG_ADDR_W-1:0]  id_rd;
  logic                   id_regwrite;
  logic                   id_memread;
  logic                   br_taken;
  logic                   pc_stall;
  logic                   ifid_stall;
  logic                   ifid_flush;
  logic                   idex_bubble;
  logic                   ex_kill;
  logic [1:0]             fwd_a;
  logic [1:0]             fwd_b;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_memread, br_taken,
    input  pc_stall, ifid_stall, ifid_flush, idex_bubble, ex_kill,
           fwd_a, fwd_b, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_memread, br_taken,
    output pc_stall, ifid_stall, ifid_flush, idex_bubble, ex_kill,
           fwd_a, fwd_b, stall_cycles
  );
endinterface

// File: rtl/legv8_hazard_unit.sv
// legv8_hazard_unit: stall, bubble, flush and forwarding control for the
// LEGv8 five-stage pipeline. The unit keeps shadow copies of the EX, MEM and WB
// instructions. All control outputs are combinational from that shadow state
// and the ID inputs.
// Optional feature macro HAZARD_FWD_EN: when it is defined, EX-stage forwarding
// is active and only a load-use stalls. When it is undefined, fwd_a/fwd_b are
// 00 and any dependency stalls until the producer has left WB.
module legv8_hazard_unit #(
  parameter int REG_ADDR_W   = 5,
  parameter int ZERO_REG     = 31,
  parameter int BRANCH_STAGE = 2,
  parameter int STALL_CNT_W  = 16
) (
  input logic                clk,
  input logic                reset,
  legv8_hazard_unit_if.slave hz
);

  typedef struct packed {
    logic                  v;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  use1;
    logic                  use2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rw;
    logic                  mr;
  } shadow_t;

  localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(ZERO_REG);

  shadow_t                s_ex_q, s_ex_d;
  shadow_t                s_mem_q, s_mem_d;
  shadow_t                s_wb_q, s_wb_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   stall_s;
  logic                   flush_s;
  logic                   pc_stall_s;
  logic                   bubble_s;
  logic                   ex_kill_s;
  logic [1:0]             fwd_a_s;
  logic [1:0]             fwd_b_s;
  logic                   unused_shadow_s;

  // A writer whose destination is XZR never creates a dependency.
  function automatic logic live_writer(input shadow_t s);
    return s.v & s.rw & (s.rd != ZERO_IDX);
  endfunction

  // The ID instruction reads a register that the shadow stage s is about to write.
  function automatic logic id_hit(input shadow_t s, input logic id_v,
                                  input logic [REG_ADDR_W-1:0] rs1,
                                  input logic [REG_ADDR_W-1:0] rs2,
                                  input logic u1, input logic u2);
    return id_v & live_writer(s) & ((u1 & (rs1 == s.rd)) | (u2 & (rs2 == s.rd)));
  endfunction

`ifdef HAZARD_FWD_EN
  // Operand select for the EX consumer. MEM is checked first so the newest producer wins.
  function automatic logic [1:0] fwd_sel(input logic cons_v,
                                         input logic [REG_ADDR_W-1:0] src,
                                         input logic used,
                                         input shadow_t mem_s, input shadow_t wb_s);
    logic [1:0] sel;
    if (cons_v & used & live_writer(mem_s) & (mem_s.rd == src)) begin
      sel = 2'b01;
    end else if (cons_v & used & live_writer(wb_s) & (wb_s.rd == src)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction
`endif

  // Hazard detection, branch flush and forwarding selects. A flush overrides a stall.
  always_comb begin
    stall_s   = 1'b0;
    flush_s   = 1'b0;
    ex_kill_s = 1'b0;
    fwd_a_s   = 2'b00;
    fwd_b_s   = 2'b00;
`ifdef HAZARD_FWD_EN
    stall_s = s_ex_q.mr & id_hit(s_ex_q, hz.id_valid, hz.id_rs1, hz.id_rs2,
                                 hz.id_use_rs1, hz.id_use_rs2);
    fwd_a_s = fwd_sel(s_ex_q.v, s_ex_q.rs1, s_ex_q.use1, s_mem_q, s_wb_q);
    fwd_b_s = fwd_sel(s_ex_q.v, s_ex_q.rs2, s_ex_q.use2, s_mem_q, s_wb_q);
`else
    stall_s = id_hit(s_ex_q,  hz.id_valid, hz.id_rs1, hz.id_rs2, hz.id_use_rs1, hz.id_use_rs2)
            | id_hit(s_mem_q, hz.id_valid, hz.id_rs1, hz.id_rs2, hz.id_use_rs1, hz.id_use_rs2)
            | id_hit(s_wb_q,  hz.id_valid, hz.id_rs1, hz.id_rs2, hz.id_use_rs1, hz.id_use_rs2);
`endif
    if (BRANCH_STAGE == 1) begin
      flush_s   = hz.br_taken & s_ex_q.v;
      ex_kill_s = 1'b0;
    end else begin
      flush_s   = hz.br_taken & s_mem_q.v;
      ex_kill_s = flush_s;
    end
    pc_stall_s = stall_s & ~flush_s;
    bubble_s   = stall_s | flush_s;
  end

  // Shadow pipeline advance and saturating stall counter next state.
  always_comb begin
    s_wb_d  = s_mem_q;
    s_mem_d = s_ex_q;
    s_ex_d  = '0;
    if (ex_kill_s) begin
      s_mem_d.v = 1'b0;
    end else begin
      s_mem_d.v = s_ex_q.v;
    end
    if (bubble_s) begin
      s_ex_d = '0;
    end else begin
      s_ex_d.v    = hz.id_valid;
      s_ex_d.rs1  = hz.id_rs1;
      s_ex_d.rs2  = hz.id_rs2;
      s_ex_d.use1 = hz.id_use_rs1;
      s_ex_d.use2 = hz.id_use_rs2;
      s_ex_d.rd   = hz.id_rd;
      s_ex_d.rw   = hz.id_regwrite;
      s_ex_d.mr   = hz.id_memread;
    end
    if (pc_stall_s & ~(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Shadow stages and counter. Asynchronous reset empties the pipeline view.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_ex_q      <= '0;
      s_mem_q     <= '0;
      s_wb_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      s_ex_q      <= s_ex_d;
      s_mem_q     <= s_mem_d;
      s_wb_q      <= s_wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.pc_stall     = pc_stall_s;
  assign hz.ifid_stall   = pc_stall_s;
  assign hz.ifid_flush   = flush_s;
  assign hz.idex_bubble  = bubble_s;
  assign hz.ex_kill      = ex_kill_s;
  assign hz.fwd_a        = fwd_a_s;
  assign hz.fwd_b        = fwd_b_s;
  assign hz.stall_cycles = stall_cnt_q;

  // Not every shadow field is consulted in every build.
  assign unused_shadow_s = ^{s_ex_q, s_mem_q, s_wb_q};

endmodule

// File: tb/tb_legv8_hazard_unit.sv
// Bench for legv8_hazard_unit. It uses hand tables for the directed pipeline
// cases, a reset-mid-stall sequence, and random stimulus against a
// queue-based pipeline model. A second instance with a 2-bit counter checks
// that the counter saturates.
module tb_legv8_hazard_unit;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } inst_t;

  typedef struct {
    bit         rst;
    inst_t      id;
    bit         br;
    bit         st;
    bit         fl;
    logic [1:0] fa;
    logic [1:0] fb;
    int         cnt;
  } vec_t;

  logic clk;
  logic reset;

  legv8_hazard_unit_if #(.REG_ADDR_W(5), .STALL_CNT_W(16)) if0 ();
  legv8_hazard_unit_if #(.REG_ADDR_W(5), .STALL_CNT_W(2))  if1 ();

  assign if1.id_valid    = if0.id_valid;
  assign if1.id_rs1      = if0.id_rs1;
  assign if1.id_rs2      = if0.id_rs2;
  assign if1.id_use_rs1  = if0.id_use_rs1;
  assign if1.id_use_rs2  = if0.id_use_rs2;
  assign if1.id_rd       = if0.id_rd;
  assign if1.id_regwrite = if0.id_regwrite;
  assign if1.id_memread  = if0.id_memread;
  assign if1.br_taken    = if0.br_taken;

  legv8_hazard_unit #(.STALL_CNT_W(16)) u_dut (.clk(clk), .reset(reset), .hz(if0));
  legv8_hazard_unit #(.STALL_CNT_W(2))  u_sat (.clk(clk), .reset(reset), .hz(if1));

  // clock generator
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
  inst_t      pipe[$];
  inst_t      cur_id;
  bit         cur_br;
  bit         m_raw, m_flush, m_pcst, m_bub;
  logic [1:0] m_fa, m_fb;
  int         m_cnt;

  inst_t i_nop, i_add1, i_sub, i_ind, i_addz, i_subz, i_ldur, i_add3, i_cbz;
  vec_t  tbl[$];

  function automatic inst_t mk(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2, input logic rw, input logic mr);
    inst_t t;
    t.v = 1'b1; t.rd = rd; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2; t.rw = rw; t.mr = mr;
    return t;
  endfunction

  function automatic vec_t row(input bit rst, input inst_t id, input bit br, input bit st,
                               input bit fl, input logic [1:0] fa, input logic [1:0] fb, input int cnt);
    vec_t r;
    r.rst = rst; r.id = id; r.br = br; r.st = st; r.fl = fl; r.fa = fa; r.fb = fb; r.cnt = cnt;
    return r;
  endfunction

  function automatic bit writes(input inst_t p, input logic [4:0] r);
    return p.v && p.rw && (p.rd != 5'd31) && (p.rd == r);
  endfunction

  function automatic bit reads_from(input inst_t id, input inst_t p);
    return id.v && ((id.u1 && writes(p, id.rs1)) || (id.u2 && writes(p, id.rs2)));
  endfunction

  // newest older producer among MEM (1) and WB (2) for the EX consumer
  function automatic logic [1:0] fwd_code(input logic [4:0] src, input logic used);
    if (!pipe[0].v || !used) return 2'b00;
    for (int i = 1; i < 3; i++) begin
      if (writes(pipe[i], src)) return 2'(i);
    end
    return 2'b00;
  endfunction

  task automatic model_reset();
    pipe.delete();
    for (int i = 0; i < 3; i++) pipe.push_back(i_nop);
    m_cnt = 0;
  endtask

  task automatic model_eval();
    m_flush = cur_br && pipe[1].v;
`ifdef HAZARD_FWD_EN
    m_raw = pipe[0].mr && reads_from(cur_id, pipe[0]);
    m_fa  = fwd_code(pipe[0].rs1, pipe[0].u1);
    m_fb  = fwd_code(pipe[0].rs2, pipe[0].u2);
`else
    m_raw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (reads_from(cur_id, pipe[i])) m_raw = 1'b1;
    end
    m_fa = 2'b00;
    m_fb = 2'b00;
`endif
    m_pcst = m_raw && !m_flush;
    m_bub  = m_raw || m_flush;
  endtask

  task automatic model_adv();
    inst_t t;
    if (m_flush) begin
      t = pipe[0]; t.v = 1'b0; pipe[0] = t;
    end
    pipe.push_front(m_bub ? i_nop : cur_id);
    void'(pipe.pop_back());
    if (m_pcst) m_cnt++;
  endtask

  task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s #%0d: got %0h expected %0h", nm, n, act, exp);
    end
  endtask

  task automatic drive(input inst_t id, input bit br);
    cur_id = id;
    cur_br = br;
    if0.id_valid    = id.v;
    if0.id_rs1      = id.rs1;
    if0.id_rs2      = id.rs2;
    if0.id_use_rs1  = id.u1;
    if0.id_use_rs2  = id.u2;
    if0.id_rd       = id.rd;
    if0.id_regwrite = id.rw;
    if0.id_memread  = id.mr;
    if0.br_taken    = br;
  endtask

  task automatic cyc_begin(input inst_t id, input bit br);
    drive(id, br);
    @(negedge clk);
    model_eval();
  endtask

  task automatic cyc_end();
    @(posedge clk);
    model_adv();
    #1;
  endtask

  task automatic do_reset();
    drive(i_nop, 1'b0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  task automatic check_row(input int n, input vec_t v);
    chk("tbl pc_stall",    n, 32'(if0.pc_stall),    32'(v.st));
    chk("tbl ifid_stall",  n, 32'(if0.ifid_stall),  32'(v.st));
    chk("tbl ifid_flush",  n, 32'(if0.ifid_flush),  32'(v.fl));
    chk("tbl idex_bubble", n, 32'(if0.idex_bubble), 32'(v.st | v.fl));
    chk("tbl ex_kill",     n, 32'(if0.ex_kill),     32'(v.fl));
    chk("tbl fwd_a",       n, 32'(if0.fwd_a),       32'(v.fa));
    chk("tbl fwd_b",       n, 32'(if0.fwd_b),       32'(v.fb));
    chk("tbl stall_cycles", n, 32'(if0.stall_cycles), 32'(v.cnt));
    chk("tbl sat_cycles",  n, 32'(if1.stall_cycles), 32'((v.cnt > 3) ? 3 : v.cnt));
  endtask

  task automatic check_model(input int n);
    chk("rnd pc_stall",    n, 32'(if0.pc_stall),    32'(m_pcst));
    chk("rnd ifid_stall",  n, 32'(if0.ifid_stall),  32'(m_pcst));
    chk("rnd ifid_flush",  n, 32'(if0.ifid_flush),  32'(m_flush));
    chk("rnd idex_bubble", n, 32'(if0.idex_bubble), 32'(m_bub));
    chk("rnd ex_kill",     n, 32'(if0.ex_kill),     32'(m_flush));
    chk("rnd fwd_a",       n, 32'(if0.fwd_a),       32'(m_fa));
    chk("rnd fwd_b",       n, 32'(if0.fwd_b),       32'(m_fb));
    chk("rnd stall_cycles", n, 32'(if0.stall_cycles), 32'((m_cnt > 65535) ? 65535 : m_cnt));
    chk("rnd sat_cycles",  n, 32'(if1.stall_cycles), 32'((m_cnt > 3) ? 3 : m_cnt));
  endtask

  function automatic logic [4:0] rnd_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  function automatic inst_t rnd_inst();
    inst_t t;
    t.v   = ($urandom_range(0, 7) != 0);
    t.rs1 = rnd_reg();
    t.rs2 = rnd_reg();
    t.rd  = rnd_reg();
    t.u1  = 1'($urandom_range(0, 1));
    t.u2  = 1'($urandom_range(0, 1));
    t.rw  = ($urandom_range(0, 3) != 0);
    t.mr  = t.rw && ($urandom_range(0, 1) == 1);
    return t;
  endfunction

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1);
  end

  // main stimulus
  initial begin
    bit hold;
    i_nop  = '0;
    i_add1 = mk(5'd1,  5'd2,  1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
    i_sub  = mk(5'd4,  5'd1,  1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    i_ind  = mk(5'd6,  5'd7,  1'b1, 5'd8, 1'b1, 1'b1, 1'b0);
    i_addz = mk(5'd31, 5'd2,  1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
    i_subz = mk(5'd4,  5'd31, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    i_ldur = mk(5'd1,  5'd2,  1'b1, 5'd0, 1'b0, 1'b1, 1'b1);
    i_add3 = mk(5'd3,  5'd1,  1'b1, 5'd1, 1'b1, 1'b1, 1'b0);
    i_cbz  = mk(5'd0,  5'd0,  1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    reset  = 1'b0;
    drive(i_nop, 1'b0);
    model_reset();

`ifdef HAZARD_FWD_EN
    tbl.push_back(row(1, i_add1, 0, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(0, i_sub,  0, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(0, i_nop,  0, 0, 0, 2'b01, 2'b00, 0));
    tbl.push_back(row(1, i_add1, 0, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(0, i_ind,  0, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(0, i_sub,  0, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(0, i_nop,  0, 0, 0, 2'b10, 2'b00, 0));
    tbl.push_back(row(1, i_addz, 0, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(0, i_subz, 0, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(0, i_nop,  0, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(1, i_ldur, 0, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(0, i_add3, 0, 1, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(0, i_add3, 0, 0, 0, 2'b00, 2'b00, 1));
    tbl.push_back(row(0, i_nop,  0, 0, 0, 2'b10, 2'b10, 1));
`else
    tbl.push_back(row(1, i_add1, 0, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(0, i_sub,  0, 1, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(0, i_sub,  0, 1, 0, 2'b00, 2'b00, 1));
    tbl.push_back(row(0, i_sub,  0, 1, 0, 2'b00, 2'b00, 2));
    tbl.push_back(row(0, i_sub,  0, 0, 0, 2'b00, 2'b00, 3));
    tbl.push_back(row(0, i_nop,  0, 0, 0, 2'b00, 2'b00, 3));
    tbl.push_back(row(1, i_add1, 0, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(0, i_ind,  0, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(0, i_sub,  0, 1, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(0, i_sub,  0, 1, 0, 2'b00, 2'b00, 1));
    tbl.push_back(row(0, i_sub,  0, 0, 0, 2'b00, 2'b00, 2));
    tbl.push_back(row(0, i_nop,  0, 0, 0, 2'b00, 2'b00, 2));
    tbl.push_back(row(1, i_addz, 0, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(0, i_subz, 0, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(0, i_nop,  0, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(1, i_ldur, 0, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(0, i_add3, 0, 1, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(0, i_add3, 0, 1, 0, 2'b00, 2'b00, 1));
    tbl.push_back(row(0, i_add3, 0, 1, 0, 2'b00, 2'b00, 2));
    tbl.push_back(row(0, i_add3, 0, 0, 0, 2'b00, 2'b00, 3));
    tbl.push_back(row(0, i_nop,  0, 0, 0, 2'b00, 2'b00, 3));
`endif
    // taken CBZ resolving in MEM while ID asks for a load-use stall
    tbl.push_back(row(1, i_cbz,  0, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(0, i_ldur, 0, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(0, i_add3, 1, 0, 1, 2'b00, 2'b00, 0));
    tbl.push_back(row(0, i_nop,  0, 0, 0, 2'b00, 2'b00, 0));

    for (int n = 0; n < tbl.size(); n++) begin
      if (tbl[n].rst) do_reset();
      cyc_begin(tbl[n].id, tbl[n].br);
      check_row(n, tbl[n]);
      cyc_end();
    end

    // asynchronous reset in the middle of a load-use stall
    do_reset();
    cyc_begin(i_ldur, 1'b0); cyc_end();
    cyc_begin(i_add3, 1'b0); cyc_end();
    for (int k = 0; k < 3; k++) begin
      cyc_begin(i_add3, 1'b0); cyc_end();
    end
    cyc_begin(i_ldur, 1'b0); cyc_end();
    cyc_begin(i_add3, 1'b0);
    chk("pre_rst pc_stall", 0, 32'(if0.pc_stall), 32'd1);
    chk("pre_rst stall_cycles", 0, 32'(if0.stall_cycles), 32'(m_cnt));
    #2 reset = 1'b0;
    #1;
    chk("rst pc_stall",     0, 32'(if0.pc_stall),     32'd0);
    chk("rst ifid_stall",   0, 32'(if0.ifid_stall),   32'd0);
    chk("rst ifid_flush",   0, 32'(if0.ifid_flush),   32'd0);
    chk("rst idex_bubble",  0, 32'(if0.idex_bubble),  32'd0);
    chk("rst ex_kill",      0, 32'(if0.ex_kill),      32'd0);
    chk("rst fwd_a",        0, 32'(if0.fwd_a),        32'd0);
    chk("rst fwd_b",        0, 32'(if0.fwd_b),        32'd0);
    chk("rst stall_cycles", 0, 32'(if0.stall_cycles), 32'd0);
    chk("rst sat_cycles",   0, 32'(if1.stall_cycles), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    cyc_begin(i_sub, 1'b0);
    chk("post_rst pc_stall", 0, 32'(if0.pc_stall), 32'd0);
    cyc_end();
    cyc_begin(i_nop, 1'b0);
    chk("post_rst fwd_a", 0, 32'(if0.fwd_a), 32'd0);
    chk("post_rst fwd_b", 0, 32'(if0.fwd_b), 32'd0);
    chk("post_rst stall_cycles", 0, 32'(if0.stall_cycles), 32'd0);
    cyc_end();

    // random traffic; ID holds its instruction while the model predicts a stall
    do_reset();
    hold = 1'b0;
    for (int c = 0; c < 800; c++) begin
      inst_t id;
      bit    br;
      id = hold ? cur_id : rnd_inst();
      br = ($urandom_range(0, 9) == 0);
      cyc_begin(id, br);
      check_model(c);
      hold = m_pcst;
      cyc_end();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
